pc_sequencer: RTL and testbench

- Program-counter sequencer for the core's instruction fetch.
- Sequences PC through straight-line code, stalls and halts.
- Resolves taken branches through the jump lookup table: drives the table's pointer input and loads its 12-bit target into PC.
- Reports run status and a cycle count to the top level and the testbench.

---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps PC through straight-line code, stalls, halts and jump-table branches.
// Optional return-address stack with Call/Ret/Fault when CALL_STACK_EN is defined.
module pc_sequencer #(
  parameter int PC_W     = 12,
  parameter int PTR_W    = 5,
  parameter int PROG_LEN = 256,
  parameter int CYC_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Branch,
  input  logic [PTR_W-1:0] Jptr_in,
  output logic [PTR_W-1:0] Jptr,
  input  logic [PC_W-1:0]  Jump,
  output logic [PC_W-1:0]  Prog_ctr,
  output logic             Running,
  output logic             Done,
  output logic [CYC_W-1:0] Cycles
`ifdef CALL_STACK_EN
  ,
  input  logic             Call,
  input  logic             Ret,
  output logic             Fault
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;

`ifdef CALL_STACK_EN
  logic [PC_W-1:0] stack [4];
  logic [2:0]      sp;
  logic [2:0]      sp_dec;
  logic            push, pop, fault_set, fault_q;

  assign sp_dec = sp - 3'd1;
  assign Fault  = fault_q;
`endif

  assign Jptr     = Jptr_in;
  assign Prog_ctr = pc;
  assign Cycles   = cyc;
  assign Running  = (state == RUN);
  assign Done     = (state == DONE_ST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cyc_nxt   = cyc;
`ifdef CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
`endif
    if (Start) begin
      state_nxt = RUN;
      pc_nxt    = '0;
      cyc_nxt   = '0;
    end else if (state == RUN) begin
      if (cyc != {CYC_W{1'b1}})
        cyc_nxt = cyc + CYC_W'(1);
      // A stalled cycle drops any Halt/Branch/Call/Ret presented with it.
      if (!Stall) begin
        if (Halt) begin
          state_nxt = DONE_ST;
`ifdef CALL_STACK_EN
        end else if (Call) begin
          if (sp == 3'd4) begin
            fault_set = 1'b1;
            state_nxt = DONE_ST;
          end else begin
            push   = 1'b1;
            pc_nxt = Jump;
          end
        end else if (Ret) begin
          if (sp == 3'd0) begin
            fault_set = 1'b1;
            state_nxt = DONE_ST;
          end else begin
            pop    = 1'b1;
            pc_nxt = stack[sp_dec[1:0]];
          end
`endif
        end else if (Branch) begin
          pc_nxt = Jump;
        end else if (pc == LAST_PC) begin
          state_nxt = DONE_ST;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sp      <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < 4; i++) stack[i] <= '0;
    end else if (Start) begin
      sp      <= '0;
      fault_q <= 1'b0;
    end else begin
      if (fault_set) fault_q <= 1'b1;
      if (push) begin
        stack[sp[1:0]] <= pc + PC_W'(1);
        sp             <= sp + 3'd1;
      end else if (pop) begin
        sp <= sp_dec;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed scoreboard bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam int PC_W = 12, PTR_W = 5, PROG_LEN = 256, CYC_W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Start = 0, Stall = 0, Halt = 0, Branch = 0;
  logic [PTR_W-1:0] Jptr_in = '0;
  logic [PTR_W-1:0] Jptr;
  logic [PC_W-1:0]  Jump;
  logic [PC_W-1:0]  Prog_ctr;
  logic             Running, Done;
  logic [CYC_W-1:0] Cycles;
`ifdef CALL_STACK_EN
  logic Call = 0, Ret = 0;
  logic Fault;
`endif

  pc_sequencer #(.PC_W(PC_W), .PTR_W(PTR_W), .PROG_LEN(PROG_LEN), .CYC_W(CYC_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .Branch(Branch), .Jptr_in(Jptr_in), .Jptr(Jptr), .Jump(Jump),
    .Prog_ctr(Prog_ctr), .Running(Running), .Done(Done), .Cycles(Cycles)
`ifdef CALL_STACK_EN
    , .Call(Call), .Ret(Ret), .Fault(Fault)
`endif
  );

  always #5 Clk = ~Clk;

  // Jump lookup table, answered combinationally from the DUT's pointer
  int table_mem [32];
  always_comb Jump = PC_W'(table_mem[Jptr]);

  typedef struct {
    int pc; bit run; bit done; int cyc; int jptr; bit fault;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;

  // Reference model
  int m_mode = M_IDLE, m_pc = 0, m_cyc = 0;
  bit m_fault = 0;
  int m_stk[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_cyc = 0; m_fault = 0; m_stk.delete();
  endtask

  task automatic step(input bit rst, input bit st, input bit stl, input bit hlt,
                      input bit br, input int jp, input bit cl = 0, input bit rt = 0);
    exp_t e;
    @(negedge Clk);
    Reset_n = rst; Start = st; Stall = stl; Halt = hlt; Branch = br;
    Jptr_in = PTR_W'(jp);
`ifdef CALL_STACK_EN
    Call = cl; Ret = rt;
`endif
    if (!rst) model_reset();
    else if (st) begin
      m_mode = M_RUN; m_pc = 0; m_cyc = 0; m_fault = 0; m_stk.delete();
    end else if (m_mode == M_RUN) begin
      if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
      if (!stl) begin
        if (hlt) m_mode = M_DONE;
`ifdef CALL_STACK_EN
        else if (cl) begin
          if (m_stk.size() == 4) begin m_fault = 1; m_mode = M_DONE; end
          else begin m_stk.push_back((m_pc + 1) % (1 << PC_W)); m_pc = table_mem[jp]; end
        end else if (rt) begin
          if (m_stk.size() == 0) begin m_fault = 1; m_mode = M_DONE; end
          else m_pc = m_stk.pop_back();
        end
`endif
        else if (br) m_pc = table_mem[jp];
        else if (m_pc == PROG_LEN - 1) m_mode = M_DONE;
        else m_pc = (m_pc + 1) % (1 << PC_W);
      end
    end
    e.pc = m_pc; e.run = (m_mode == M_RUN); e.done = (m_mode == M_DONE);
    e.cyc = m_cyc; e.jptr = jp; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per clock edge issued by the stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("prog_ctr", int'(Prog_ctr), e.pc);
        chk("running", int'(Running), int'(e.run));
        chk("done", int'(Done), int'(e.done));
        chk("cycles", int'(Cycles), e.cyc);
        chk("jptr", int'(Jptr), e.jptr);
`ifdef CALL_STACK_EN
        chk("fault", int'(Fault), int'(e.fault));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) table_mem[i] = $urandom_range(0, 300);
    table_mem[1] = 9; table_mem[2] = 77; table_mem[3] = 83;

    // Reset held two cycles, then a full straight-line run to completion
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(259);

    // Branch at PC 3 through pointer 1 (target 9)
    step(1, 1, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 1, 1);
    idle(2);

    // Stall for three cycles at PC 5 with a Branch that must be dropped
    step(1, 1, 0, 0, 0, 0);
    idle(5);
    step(1, 0, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    idle(2);

    // Halt and Branch together at PC 4, then restart
    step(1, 1, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 1, 1, 2);
    idle(2);
    step(1, 1, 0, 0, 0, 0);
    idle(1);

    // Asynchronous reset mid-cycle at PC 20
    step(1, 1, 0, 0, 0, 0);
    idle(20);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", int'(Prog_ctr), 0);
    chk("async_rst_running", int'(Running), 0);
    chk("async_rst_done", int'(Done), 0);
    chk("async_rst_cycles", int'(Cycles), 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0);
    idle(2);

`ifdef CALL_STACK_EN
    // Call at PC 2 to 83, Ret at 85 back to 3, then overflow the stack
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 3, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 3, 1, 0);
    idle(2);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
`endif

    // Randomised traffic with a fresh table
    for (int i = 0; i < 32; i++) table_mem[i] = $urandom_range(0, 270);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(($urandom_range(0, 499) != 0), (r < 2), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 2),
           $urandom_range(0, 31), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 19) == 0));
    end

    @(posedge Clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
